sync_receiver_baud: RTL and testbench

UART receive stage of the host-to-FPGA command link. It sits downstream of the 32-bit serial transmitter. It oversamples the asynchronous serial line at 16x and recovers 8N1 bytes, LSB first. Every four good bytes (least-significant byte first) are assembled into one 32-bit word for the motor-control logic, which receives it with a single-cycle valid strobe.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_tick_gen.sv | 29 ++
 rtl/sync_receiver_baud.sv | 175 +++++++++++++++++
 tb/tb_sync_receiver_baud.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE     = 16;
  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every BAUD_DIV clocks while enabled,
// counter held at zero while disabled so the tick phase follows the enable edge.
module rx_tick_gen #(
  parameter int BAUD_DIV = 326
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else if (!en || cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = en && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/sync_receiver_baud.sv
// 16x oversampling 8N1 receiver that packs four good bytes (LSB byte first)
// into one 32-bit word with a single-cycle valid strobe.
module sync_receiver_baud
  import uart_pkg::*;
#(
  parameter int BAUD_DIV     = 326,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_ser,
  output logic [31:0] Data_out,
  output logic        Data_valid,
  output logic        Frame_err,
  output logic        Busy
);

  localparam int TO_W = $clog2(TIMEOUT_BITS * OVERSAMPLE + 1);
  localparam logic [TO_W-1:0] TO_TERM = TO_W'(TIMEOUT_BITS * OVERSAMPLE);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_BITS * OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

  rx_state_t            state_reg;
  logic                 sync1_reg;
  logic                 rx_reg;
  logic [3:0]           os_cnt_reg;
  logic [2:0]           bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           byte_idx_reg;
  logic [7:0]           word_buf_reg [0:BYTES_PER_WORD-2];
  logic [TO_W-1:0]      to_cnt_reg;
  logic [31:0]          data_out_reg;
  logic                 data_valid_reg;
  logic                 frame_err_reg;
  logic                 busy_reg;

  logic bit_tick;
  logic idle_tick;
  logic bit_tick_en;
  logic idle_tick_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_reg <= 1'b1;
      rx_reg    <= 1'b1;
    end else begin
      sync1_reg <= IN_ser;
      rx_reg    <= sync1_reg;
    end
  end

  // Bit-timing ticks restart on every start detection; the idle tick times the
  // inter-byte gap only while a word is partially assembled.
  assign bit_tick_en  = (state_reg != IDLE);
  assign idle_tick_en = (state_reg == IDLE) && (byte_idx_reg != 2'd0);

  rx_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_bit_tick (
    .CLK  (CLK),
    .RST  (RST),
    .en   (bit_tick_en),
    .tick (bit_tick)
  );

  rx_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_idle_tick (
    .CLK  (CLK),
    .RST  (RST),
    .en   (idle_tick_en),
    .tick (idle_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      os_cnt_reg     <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      byte_idx_reg   <= '0;
      to_cnt_reg     <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
        word_buf_reg[i] <= '0;
      end
    end else begin
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (!rx_reg) begin
            state_reg  <= START;
            os_cnt_reg <= '0;
            to_cnt_reg <= '0;
          end else if (idle_tick && to_cnt_reg != TO_TERM) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (to_cnt_reg == TO_LAST) begin
              byte_idx_reg <= '0;
            end
          end
        end
        START: begin
          if (bit_tick) begin
            if (os_cnt_reg == OS_MID) begin
              if (rx_reg) begin
                state_reg <= IDLE;
              end else begin
                state_reg   <= DATA;
                os_cnt_reg  <= '0;
                bit_cnt_reg <= '0;
              end
            end else begin
              os_cnt_reg <= os_cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (bit_tick) begin
            os_cnt_reg <= os_cnt_reg + 1'b1;
            if (os_cnt_reg == OS_LAST) begin
              shift_reg   <= {rx_reg, shift_reg[DATA_BITS-1:1]};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == BIT_LAST) begin
                state_reg <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            os_cnt_reg <= os_cnt_reg + 1'b1;
            if (os_cnt_reg == OS_LAST) begin
              if (rx_reg) begin
                for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                  if (byte_idx_reg == 2'(i)) begin
                    word_buf_reg[i] <= shift_reg;
                  end
                end
                if (byte_idx_reg == IDX_LAST) begin
                  data_out_reg   <= {shift_reg, word_buf_reg[2], word_buf_reg[1], word_buf_reg[0]};
                  data_valid_reg <= 1'b1;
                  byte_idx_reg   <= '0;
                end else begin
                  byte_idx_reg <= byte_idx_reg + 1'b1;
                end
                state_reg <= IDLE;
              end else begin
                frame_err_reg <= 1'b1;
                byte_idx_reg  <= '0;
                state_reg     <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          // A line held low must go high before a new start can be seen.
          if (rx_reg) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Data_out   = data_out_reg;
  assign Data_valid = data_valid_reg;
  assign Frame_err  = frame_err_reg;
  assign Busy       = busy_reg;

endmodule

// File: tb/tb_sync_receiver_baud.sv
// Scoreboard bench for sync_receiver_baud: stimulus pushes expected words, a
// monitor pops and compares on every Data_valid strobe.
module tb_sync_receiver_baud;

  localparam int BAUD_DIV     = 4;
  localparam int TIMEOUT_BITS = 20;
  localparam int BIT_CYC      = BAUD_DIV * 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_ser = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  sync_receiver_baud #(
    .BAUD_DIV     (BAUD_DIV),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .IN_ser     (in_ser),
    .Data_out   (data_out),
    .Data_valid (data_valid),
    .Frame_err  (frame_err),
    .Busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: one line per received word, compared against the scoreboard.
  always @(negedge clk) begin
    if (data_valid || frame_err) begin
      check("pulse_exclusive", {31'b0, data_valid & frame_err}, 32'h0);
    end
    if (frame_err) begin
      ferr_seen++;
      $display("t=%0t frame error pulse #%0d", $time, ferr_seen);
    end
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h, required no word", data_out);
      end else begin
        logic [31:0] exp_w;
        exp_w = exp_q.pop_front();
        $display("t=%0t word got %h expected %h", $time, data_out, exp_w);
        check("word", data_out, exp_w);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    in_ser = b;
    wait_cycles(BIT_CYC);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic settle(input string name);
    wait_cycles(BIT_CYC);
    check({"drained_", name}, exp_q.size(), 32'd0);
    check({"frame_err_count_", name}, ferr_seen, ferr_exp);
  endtask

  initial begin
    logic [7:0] partial;

    // Reset state
    wait_cycles(4);
    check("reset_data_out", data_out, 32'h0);
    check("reset_valid", {31'b0, data_valid}, 32'h0);
    check("reset_frame_err", {31'b0, frame_err}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    wait_cycles(BIT_CYC);

    // 1: 0x01,0x00,0x00,0x00
    exp_q.push_back(32'h00000001);
    send_bit(1'b0);
    check("busy_mid_frame", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 8; i++) send_bit(i == 0);
    send_bit(1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    settle("s1");

    // 2: DEADBEEF back-to-back
    send_word(32'hDEADBEEF);
    settle("s2");

    // 3: 12-cycle glitch
    in_ser = 1'b0;
    wait_cycles(12);
    check("glitch_busy_rise", {31'b0, busy}, 32'h1);
    in_ser = 1'b1;
    for (int i = 0; i < 40 && busy; i++) wait_cycles(1);
    check("glitch_busy_fall", {31'b0, busy}, 32'h0);
    settle("s3");

    // 4: bad stop bit, line held low 20 more bits, then a good word
    ferr_exp++;
    send_byte(8'h55, 1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    in_ser = 1'b1;
    wait_cycles(2 * BIT_CYC);
    send_word(32'h11223344);
    settle("s4");

    // 5: partial word dropped by idle timeout
    exp_q.push_back(32'h12345678);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    wait_cycles(25 * BIT_CYC);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    settle("s5");

    // 6: reset mid-way through byte 2 of a word
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    partial = 8'h33;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    #3 rst = 1'b1;
    #1;
    check("rst_async_data_out", data_out, 32'h0);
    check("rst_async_busy", {31'b0, busy}, 32'h0);
    check("rst_async_valid", {31'b0, data_valid}, 32'h0);
    check("rst_async_frame_err", {31'b0, frame_err}, 32'h0);
    wait_cycles(3);
    in_ser = 1'b1;
    rst = 1'b0;
    wait_cycles(2 * BIT_CYC);
    send_word(32'hCAFEF00D);
    settle("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
